// File: rtl/pe_sequencer.sv
// ----------------------------------------------------------------------------
// pe_sequencer
//   Control sequencer for one row-stationary PE. Loads a filter row (S beats)
//   and an ifmap row (S+E-1 beats) into the scratchpads, runs S*E MAC cycles,
//   waits PIPE_LAT cycles for the PE pipeline to drain, optionally accumulates
//   the upstream psums, then streams E psums downstream and pulses done.
//
//   Optional feature: define PE_SEQ_PSUM_ACC_EN to include the ACC state that
//   adds the upstream PE's psums before output. Without it DRAIN goes straight
//   to OUT, en_psum_in is tied 0 and psum_in_valid is ignored.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   start, abort              begin a job / cancel the running job
//   cfg_s, cfg_e              filter row length S, output row length E
//   filt_valid/filt_ready     filter load stream handshake
//   ifmap_valid/ifmap_ready   ifmap load stream handshake
//   psum_in_valid             upstream psum present (ACC only)
//   psum_out_ready            downstream accepts psum
//   load_filter/load_ifmap    scratchpad write strobes
//   ld_addr_filter/_ifmap     scratchpad write addresses
//   sel_filter_addr/_ifmap    scratchpad read addresses during compute
//   psum_sel                  psum entry select
//   pe_en, en_psum_in/out     PE datapath enables
//   busy, done, cfg_err       status; done and cfg_err are 1-cycle pulses
// ----------------------------------------------------------------------------
module pe_sequencer #(
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] cfg_s,
    input  logic [3:0] cfg_e,
    input  logic       filt_valid,
    output logic       filt_ready,
    input  logic       ifmap_valid,
    output logic       ifmap_ready,
    input  logic       psum_in_valid,
    input  logic       psum_out_ready,
    output logic       load_filter,
    output logic       load_ifmap,
    output logic [5:0] ld_addr_filter,
    output logic [3:0] ld_addr_ifmap,
    output logic [5:0] sel_filter_addr,
    output logic [3:0] sel_ifmap_addr,
    output logic [3:0] psum_sel,
    output logic       pe_en,
    output logic       en_psum_in,
    output logic       en_psum_out,
    output logic       busy,
    output logic       done,
    output logic       cfg_err
);

    typedef enum logic [2:0] {
        StIdle, StLdFilt, StLdIfmap, StCompute, StDrain, StAcc, StOut, StFinish
    } state_e;

    state_e     state_q;
    logic [3:0] s_len_q, e_len_q;
    logic [3:0] cnt_s_q;   // load beat count, then filter index s
    logic [3:0] cnt_e_q;   // output index e
    logic [2:0] lat_q;
    logic       cfg_err_q;

    logic       cfg_ok;
    logic [4:0] w_len;
    logic       last_s, last_e;

    // S+E-1 <= 16 checked as S+E <= 17 in 5 bits so nothing can overflow.
    assign cfg_ok = (cfg_s != 4'd0) && (cfg_e != 4'd0) &&
                    (({1'b0, cfg_s} + {1'b0, cfg_e}) <= 5'd17);
    assign w_len  = {1'b0, s_len_q} + {1'b0, e_len_q} - 5'd1;
    assign last_s = (cnt_s_q == s_len_q - 4'd1);
    assign last_e = (cnt_e_q == e_len_q - 4'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            s_len_q   <= 4'd0;
            e_len_q   <= 4'd0;
            cnt_s_q   <= 4'd0;
            cnt_e_q   <= 4'd0;
            lat_q     <= 3'd0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            if (abort && state_q != StIdle) begin
                state_q <= StIdle;
                cnt_s_q <= 4'd0;
                cnt_e_q <= 4'd0;
                lat_q   <= 3'd0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            if (cfg_ok) begin
                                s_len_q <= cfg_s;
                                e_len_q <= cfg_e;
                                cnt_s_q <= 4'd0;
                                cnt_e_q <= 4'd0;
                                state_q <= StLdFilt;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end
                    StLdFilt: begin
                        if (load_filter) begin
                            if (last_s) begin
                                cnt_s_q <= 4'd0;
                                state_q <= StLdIfmap;
                            end else begin
                                cnt_s_q <= cnt_s_q + 4'd1;
                            end
                        end
                    end
                    StLdIfmap: begin
                        if (load_ifmap) begin
                            if ({1'b0, cnt_s_q} == w_len - 5'd1) begin
                                cnt_s_q <= 4'd0;
                                state_q <= StCompute;
                            end else begin
                                cnt_s_q <= cnt_s_q + 4'd1;
                            end
                        end
                    end
                    StCompute: begin
                        if (last_s) begin
                            if (last_e) begin
                                // Counters stay put so DRAIN holds the last addresses.
                                lat_q   <= 3'd0;
                                state_q <= StDrain;
                            end else begin
                                cnt_s_q <= 4'd0;
                                cnt_e_q <= cnt_e_q + 4'd1;
                            end
                        end else begin
                            cnt_s_q <= cnt_s_q + 4'd1;
                        end
                    end
                    StDrain: begin
                        if (lat_q == 3'(PIPE_LAT - 1)) begin
                            cnt_s_q <= 4'd0;
                            cnt_e_q <= 4'd0;
`ifdef PE_SEQ_PSUM_ACC_EN
                            state_q <= StAcc;
`else
                            state_q <= StOut;
`endif
                        end else begin
                            lat_q <= lat_q + 3'd1;
                        end
                    end
`ifdef PE_SEQ_PSUM_ACC_EN
                    StAcc: begin
                        if (en_psum_in) begin
                            if (last_e) begin
                                cnt_e_q <= 4'd0;
                                state_q <= StOut;
                            end else begin
                                cnt_e_q <= cnt_e_q + 4'd1;
                            end
                        end
                    end
`endif
                    StOut: begin
                        if (psum_out_ready) begin
                            if (last_e) begin
                                cnt_e_q <= 4'd0;
                                state_q <= StFinish;
                            end else begin
                                cnt_e_q <= cnt_e_q + 4'd1;
                            end
                        end
                    end
                    StFinish: state_q <= StIdle;
                    default:  state_q <= StIdle;
                endcase
            end
        end
    end

    // Outputs decode the state registers; only the ready/strobe/en_psum_in
    // paths see live inputs, and abort masks them so it beats any handshake.
    always_comb begin
        filt_ready      = (state_q == StLdFilt) && !abort;
        ifmap_ready     = (state_q == StLdIfmap) && !abort;
        load_filter     = filt_valid && filt_ready;
        load_ifmap      = ifmap_valid && ifmap_ready;
        ld_addr_filter  = (state_q == StLdFilt) ? {2'b00, cnt_s_q} : 6'd0;
        ld_addr_ifmap   = (state_q == StLdIfmap) ? cnt_s_q : 4'd0;
        pe_en           = (state_q == StCompute) || (state_q == StDrain);
        sel_filter_addr = pe_en ? {2'b00, cnt_s_q} : 6'd0;
        sel_ifmap_addr  = pe_en ? (cnt_s_q + cnt_e_q) : 4'd0;
        psum_sel        = (pe_en || state_q == StAcc || state_q == StOut) ? cnt_e_q : 4'd0;
`ifdef PE_SEQ_PSUM_ACC_EN
        en_psum_in      = (state_q == StAcc) && psum_in_valid && !abort;
`else
        en_psum_in      = 1'b0;
`endif
        en_psum_out     = (state_q == StOut);
        busy            = (state_q != StIdle);
        done            = (state_q == StFinish);
        cfg_err         = cfg_err_q;
    end

`ifndef PE_SEQ_PSUM_ACC_EN
    logic unused_psum_in_valid;
    assign unused_psum_in_valid = psum_in_valid;
`endif

endmodule

// File: tb/tb_pe_sequencer.sv
module tb_pe_sequencer;

    localparam int PipeLat = 2;
`ifdef PE_SEQ_PSUM_ACC_EN
    localparam bit AccEn = 1'b1;
`else
    localparam bit AccEn = 1'b0;
`endif

    logic       clk, rst, start, abort;
    logic [3:0] cfg_s, cfg_e;
    logic       filt_valid, filt_ready, ifmap_valid, ifmap_ready;
    logic       psum_in_valid, psum_out_ready;
    logic       load_filter, load_ifmap;
    logic [5:0] ld_addr_filter, sel_filter_addr;
    logic [3:0] ld_addr_ifmap, sel_ifmap_addr, psum_sel;
    logic       pe_en, en_psum_in, en_psum_out, busy, done, cfg_err;

    pe_sequencer #(.PIPE_LAT(PipeLat)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_s(cfg_s), .cfg_e(cfg_e),
        .filt_valid(filt_valid), .filt_ready(filt_ready),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
        .psum_in_valid(psum_in_valid), .psum_out_ready(psum_out_ready),
        .load_filter(load_filter), .load_ifmap(load_ifmap),
        .ld_addr_filter(ld_addr_filter), .ld_addr_ifmap(ld_addr_ifmap),
        .sel_filter_addr(sel_filter_addr), .sel_ifmap_addr(sel_ifmap_addr),
        .psum_sel(psum_sel), .pe_en(pe_en), .en_psum_in(en_psum_in),
        .en_psum_out(en_psum_out), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- behavioural model ----------------
    // Job = sequence of phases; k counts completed items in the current phase.
    // 0 idle, 1 filter load, 2 ifmap load, 3 compute, 4 drain, 5 acc, 6 out, 7 finish
    int ph = 0, k = 0, ms = 0, me = 0;
    bit err_p = 0;

    function automatic int phase_len(input int p);
        case (p)
            1: return ms;
            2: return ms + me - 1;
            3: return ms * me;
            4: return PipeLat;
            5, 6: return me;
            default: return 1;
        endcase
    endfunction

    function automatic int next_phase(input int p);
        if (p == 4) return AccEn ? 5 : 6;
        if (p == 7) return 0;
        return p + 1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph = 0; k = 0; ms = 0; me = 0; err_p = 0;
        end else begin
            bit fire;
            err_p = 0;
            if (ph == 0) begin
                if (start) begin
                    if (cfg_s >= 1 && cfg_e >= 1 && int'(cfg_s) + int'(cfg_e) - 1 <= 16) begin
                        ms = cfg_s; me = cfg_e; ph = 1; k = 0;
                    end else begin
                        err_p = 1;
                    end
                end
            end else if (abort) begin
                ph = 0; k = 0;
            end else begin
                case (ph)
                    1: fire = filt_valid;
                    2: fire = ifmap_valid;
                    5: fire = psum_in_valid;
                    6: fire = psum_out_ready;
                    default: fire = 1;
                endcase
                if (fire) begin
                    k++;
                    if (k == phase_len(ph)) begin
                        ph = next_phase(ph); k = 0;
                    end
                end
            end
        end
    end

    // Compare every cycle while out of reset.
    always @(negedge clk) begin
        if (rst) begin
            int s, e, fr, ir, sf, si, ps, pe;
            fr = (ph == 1 && !abort) ? 1 : 0;
            ir = (ph == 2 && !abort) ? 1 : 0;
            s = 0; e = 0; sf = 0; si = 0; ps = 0; pe = 0;
            if (ph == 3) begin s = k % ms; e = k / ms; end
            if (ph == 4) begin s = ms - 1; e = me - 1; end
            if (ph == 3 || ph == 4) begin pe = 1; sf = s; si = s + e; ps = e; end
            if (ph == 5 || ph == 6) ps = k;
            chk("busy", busy, ph != 0);
            chk("done", done, ph == 7);
            chk("cfg_err", cfg_err, err_p);
            chk("filt_ready", filt_ready, fr);
            chk("ifmap_ready", ifmap_ready, ir);
            chk("load_filter", load_filter, fr & filt_valid);
            chk("load_ifmap", load_ifmap, ir & ifmap_valid);
            chk("ld_addr_filter", ld_addr_filter, ph == 1 ? k : 0);
            chk("ld_addr_ifmap", ld_addr_ifmap, ph == 2 ? k : 0);
            chk("pe_en", pe_en, pe);
            chk("sel_filter_addr", sel_filter_addr, sf);
            chk("sel_ifmap_addr", sel_ifmap_addr, si);
            chk("psum_sel", psum_sel, ps);
            chk("en_psum_in", en_psum_in, (ph == 5 && psum_in_valid && !abort) ? 1 : 0);
            chk("en_psum_out", en_psum_out, ph == 6);
        end
    end

    // ---------------- observation logs ----------------
    int wq_f[$], wq_i[$], pe_q[$], out_q[$], in_q[$];
    int done_cnt, done_cyc, err_cnt, busy_cnt, last_wf_cyc;

    always @(negedge clk) begin
        if (rst) begin
            if (load_filter) begin wq_f.push_back(ld_addr_filter); last_wf_cyc = cyc; end
            if (load_ifmap) wq_i.push_back(ld_addr_ifmap);
            if (pe_en) pe_q.push_back(sel_ifmap_addr);
            if (en_psum_out) out_q.push_back(psum_sel);
            if (en_psum_in) in_q.push_back(psum_sel);
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (cfg_err) err_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic clear_logs();
        wq_f.delete(); wq_i.delete(); pe_q.delete(); out_q.delete(); in_q.delete();
        done_cnt = 0; done_cyc = 0; err_cnt = 0; busy_cnt = 0; last_wf_cyc = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin tick(); n++; end
        chk("done_seen", done_cnt > 0, 1);
        tick();
    endtask

    task automatic wait_out(input int budget);
        int n = 0;
        while (!en_psum_out && n < budget) begin tick(); n++; end
        chk("out_reached", en_psum_out, 1);
    endtask

    task automatic kick(input int s, input int e, output int t0);
        cfg_s = 4'(s); cfg_e = 4'(e);
        start = 1; t0 = cyc;
        tick();
        start = 0;
    endtask

    initial begin
        int t0;
        int exp_pe[6] = '{0, 1, 2, 1, 2, 3};
        int exp_out[6] = '{0, 1, 1, 1, 1, 2};
        rst = 0; start = 0; abort = 0; cfg_s = 0; cfg_e = 0;
        filt_valid = 0; ifmap_valid = 0; psum_in_valid = 0; psum_out_ready = 0;
        #200000 ;
    end

    initial begin
        int t0;
        int exp_pe[6] = '{0, 1, 2, 1, 2, 3};
        int exp_out[6] = '{0, 1, 1, 1, 1, 2};
        #1;
        clear_logs();
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_pe_en", pe_en, 0);
        chk("rst_filt_ready", filt_ready, 0);
        chk("rst_psum_sel", psum_sel, 0);

        // Reference job; start issued in the reset-release cycle.
        filt_valid = 1; ifmap_valid = 1; psum_out_ready = 1; psum_in_valid = 1;
        rst = 1;
        kick(3, 4, t0);
        chk("release_start_busy", busy, 1);
        wait_done(80);
        chk("t1_done_cycle", done_cyc - t0, AccEn ? 32 : 28);
        chk("t1_filt_writes", wq_f.size(), 3);
        chk("t1_ifmap_writes", wq_i.size(), 6);
        chk("t1_pe_cycles", pe_q.size(), 12 + PipeLat);
        for (int i = 0; i < 6 && i < pe_q.size(); i++)
            chk($sformatf("t1_ifmap_addr%0d", i), pe_q[i], exp_pe[i]);
        chk("t1_out_count", out_q.size(), 4);
        chk("t1_en_psum_in", in_q.size(), AccEn ? 4 : 0);

        // Illegal configurations.
        clear_logs();
        kick(10, 8, t0);
        kick(9, 9, t0);
        kick(0, 5, t0);
        repeat (3) tick();
        chk("t2_cfg_err_pulses", err_cnt, 3);
        chk("t2_busy_cycles", busy_cnt, 0);

        // Largest legal ifmap row (S+E-1 = 16).
        clear_logs();
        kick(8, 9, t0);
        wait_done(200);
        chk("t2b_ifmap_writes", wq_i.size(), 16);
        if (wq_i.size() == 16) chk("t2b_last_ifmap_addr", wq_i[15], 15);

        // Filter stream valid on alternate cycles.
        clear_logs();
        filt_valid = 0;
        kick(4, 1, t0);
        for (int i = 0; i < 7; i++) begin
            filt_valid = (i % 2 == 0);
            tick();
        end
        filt_valid = 0;
        wait_done(80);
        chk("t3_filt_writes", wq_f.size(), 4);
        for (int i = 0; i < 4 && i < wq_f.size(); i++)
            chk($sformatf("t3_filt_addr%0d", i), wq_f[i], i);
        chk("t3_last_write_cycle", last_wf_cyc - t0, 7);
        filt_valid = 1;

        // Abort in COMPUTE at s=1, e=2.
        clear_logs();
        kick(3, 4, t0);
        for (int n = 0; n < 40 && cyc < t0 + 17; n++) tick();
        chk("t4_pre_s", sel_filter_addr, 1);
        chk("t4_pre_e", psum_sel, 2);
        chk("t4_pre_ifmap", sel_ifmap_addr, 3);
        abort = 1;
        tick();
        abort = 0;
        chk("t4_post_busy", busy, 0);
        chk("t4_post_pe_en", pe_en, 0);
        repeat (40) tick();
        chk("t4_no_done", done_cnt, 0);

        // Downstream stalls 3 cycles in OUT.
        clear_logs();
        kick(2, 3, t0);
        wait_out(80);
        tick();
        psum_out_ready = 0;
        repeat (3) tick();
        psum_out_ready = 1;
        wait_done(40);
        chk("t5_out_cycles", out_q.size(), 6);
        for (int i = 0; i < 6 && i < out_q.size(); i++)
            chk($sformatf("t5_psum_sel%0d", i), out_q[i], exp_out[i]);

        // Asynchronous reset in the middle of OUT.
        clear_logs();
        kick(2, 3, t0);
        wait_out(80);
        #2 rst = 0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_en_psum_out", en_psum_out, 0);
        chk("t6_psum_sel", psum_sel, 0);
        chk("t6_done", done, 0);
        tick();
        rst = 1;
        tick();
        chk("t6_idle_after", busy, 0);

`ifdef PE_SEQ_PSUM_ACC_EN
        // Upstream psums arrive 5 cycles after ACC entry.
        clear_logs();
        psum_in_valid = 0;
        kick(2, 2, t0);
        for (int n = 0; n < 40 && cyc < t0 + 17; n++) tick();
        psum_in_valid = 1;
        wait_done(40);
        chk("t7_in_count", in_q.size(), 2);
        if (in_q.size() == 2) begin
            chk("t7_in_sel0", in_q[0], 0);
            chk("t7_in_sel1", in_q[1], 1);
        end
        chk("t7_done_cycle", done_cyc - t0, 21);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #150000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 2: PE pipeline depth (spad read to adder write) in cycles, range 1..7.
REQ-002 SHALL have ports (name  direction  width  meaning):
  clk  in  1  sole clock, rising edge
  rst  in  1  asynchronous active-low reset
  start  in  1  pulse; begin one job
  abort  in  1  synchronous job cancel
  cfg_s  in  4  filter row length S, 1..15
  cfg_e  in  4  output row length E, 1..15
  filt_valid / filt_ready  in / out  1 / 1  filter stream handshake
  ifmap_valid / ifmap_ready  in / out  1 / 1  ifmap stream handshake
  psum_in_valid  in  1  upstream PE psum present
  psum_out_ready  in  1  downstream accepts psum
  load_filter, load_ifmap  out  1  spad write strobes
  ld_addr_filter  out  6  filter write address
  ld_addr_ifmap  out  4  ifmap write address
  sel_filter_addr  out  6  filter read address
  sel_ifmap_addr  out  4  ifmap read address
  psum_sel  out  4  psum entry select
  pe_en, en_psum_in, en_psum_out  out  1  PE enables
  busy, done, cfg_err  out  1  status; done, cfg_err are 1-cycle pulses

Function
REQ-003 SHALL implement states IDLE, LD_FILT, LD_IFMAP, COMPUTE, DRAIN, ACC, OUT, FINISH.
REQ-004 IDLE: start with 1<=cfg_s, 1<=cfg_e, cfg_s+cfg_e-1<=16 SHALL latch cfg_s/cfg_e and enter LD_FILT next cycle; otherwise SHALL pulse cfg_err and stay IDLE.
REQ-005 start outside IDLE SHALL be ignored; busy SHALL be 1 in every state except IDLE.
REQ-006 LD_FILT: filt_ready=1; load_filter = filt_valid & filt_ready; ld_addr_filter = beat count from 0; after S accepted beats -> LD_IFMAP.
REQ-007 LD_IFMAP: same rules with ifmap signals, W = S+E-1 beats, addresses 0..W-1 -> COMPUTE.
REQ-008 Load strobes SHALL never assert outside their LD state; the two streams SHALL never be accepted in the same cycle.
REQ-009 COMPUTE: one MAC per cycle, pe_en=1, loop e=0..E-1 outer, s=0..S-1 inner; sel_filter_addr=s, sel_ifmap_addr=e+s, psum_sel=e; exactly S*E cycles.
REQ-010 DRAIN: pe_en=1, addresses held at last COMPUTE value, PIPE_LAT cycles, then ACC (if enabled) else OUT.
REQ-011 ACC: for e=0..E-1, psum_sel=e; en_psum_in = psum_in_valid; e advances only on en_psum_in; after E -> OUT.
REQ-012 OUT: en_psum_out=1, psum_sel=e; e advances when psum_out_ready=1; after E transfers -> FINISH.
REQ-013 FINISH: done=1 for one cycle, then IDLE.
REQ-014 abort in any non-IDLE state SHALL return to IDLE next cycle, deassert all strobes/enables, no done; abort wins over any simultaneous handshake.
REQ-015 Address counters SHALL never exceed their loop bound; no wrap-around reachable with legal config.

Reset
REQ-016 rst=0 SHALL asynchronously force IDLE; all outputs 0; counters and latched config 0.
REQ-017 Reset release SHALL be honoured on the next rising clk; start in that cycle is accepted.

Configuration
REQ-018 Macro PE_SEQ_PSUM_ACC_EN defined: ACC state present per REQ-011. Undefined: ACC removed, DRAIN -> OUT directly, en_psum_in tied 0, psum_in_valid ignored.

Verification
REQ-019 S=3,E=4, streams always valid, psum_out_ready=1, macro off -> LD_FILT 3 cycles, LD_IFMAP 6, COMPUTE 12 with ifmap addr 0,1,2,1,2,3,..., DRAIN 2, OUT 4, done at cycle 28 after start.
REQ-020 cfg_s=10, cfg_e=8 -> cfg_err pulse, busy stays 0.
REQ-021 filt_valid toggled 1/0 each cycle, S=4 -> 4 writes at addresses 0..3 over 7 cycles, no write on invalid cycles.
REQ-022 Macro on, S=2,E=2, psum_in_valid asserted 5 cycles after entering ACC -> en_psum_in high with psum_sel 0 then 1, OUT follows.
REQ-023 abort mid-COMPUTE at s=1,e=2 -> next cycle IDLE, pe_en=0, no done; rst=0 mid-OUT -> all outputs 0 same cycle without clk edge.
REQ-024 psum_out_ready=0 for 3 cycles during OUT -> psum_sel held, en_psum_out held 1, no entry skipped.
